// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller (master) and the shared datapath (slave).
// instruction/zero/dmem_ready flow toward the controller; every strobe and select flows out.
interface multicycle_controller_if #(
  parameter int ALUOP_W = 4
);
  logic [31:0]        instruction;
  logic               zero;
  logic               dmem_ready;
  logic               pc_write;
  logic               pc_src;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         wb_sel;
  logic               alu_src_a;
  logic               alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [2:0]         imm_sel;
  logic               dmem_req;
  logic               dmem_we;
  logic               halted;
  logic               fault;
  logic [31:0]        retired;

  modport master (
    input  instruction, zero, dmem_ready,
    output pc_write, pc_src, ir_write, reg_write, wb_sel, alu_src_a, alu_src_b,
           alu_op, imm_sel, dmem_req, dmem_we, halted, fault, retired
  );

  modport slave (
    output instruction, zero, dmem_ready,
    input  pc_write, pc_src, ir_write, reg_write, wb_sel, alu_src_a, alu_src_b,
           alu_op, imm_sel, dmem_req, dmem_we, halted, fault, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT driving the shared datapath.
// Strobes/selects decode from the registered state plus the latched instruction.
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui, is_sys, br_ok, legal;
  logic [ALUOP_W-1:0] alu_fn;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign f7b5   = bus.instruction[30];

  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_ld  = (opcode == 7'b0000011);
  assign is_st  = (opcode == 7'b0100011);
  assign is_br  = (opcode == 7'b1100011);
  assign is_jal = (opcode == 7'b1101111);
  assign is_lui = (opcode == 7'b0110111);
  assign is_sys = (opcode == 7'b1110011);
  assign br_ok  = is_br && (funct3 == 3'b000 || funct3 == 3'b001);
  assign legal  = is_r || is_i || is_ld || is_st || br_ok || is_jal || is_lui;

  // funct7[5] selects SUB only for register-register; for immediates it only matters on shifts.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_sys) begin
          state_d = S_HALT;
        end else if (!legal) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = 8'd0;
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_r || is_i || is_lui) begin
          state_d = S_WB;
        end else begin
          state_d   = S_FETCH;
          retired_d = retired_q + 32'd1;
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (is_st) begin
            state_d   = S_FETCH;
            retired_d = retired_q + 32'd1;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 32'd1;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 8'd0;
      fault_q   <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  logic               pc_write_c, pc_src_c, ir_write_c, reg_write_c;
  logic [1:0]         wb_sel_c;
  logic               alu_src_a_c, alu_src_b_c;
  logic [ALUOP_W-1:0] alu_op_c;
  logic [2:0]         imm_sel_c;
  logic               dmem_req_c, dmem_we_c, halted_c;

  always_comb begin
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = 2'd0;
    alu_src_a_c = 1'b0;
    alu_src_b_c = 1'b0;
    alu_op_c    = ALU_ADD;
    imm_sel_c   = 3'd0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    halted_c    = 1'b0;

    // ALU operands stay put through MEM/WB so the address/result remains valid downstream.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_src_a_c = is_jal;
      alu_src_b_c = is_i || is_ld || is_st || is_jal || is_lui;
      if (is_r || is_i) alu_op_c = alu_fn;
      else if (is_br)   alu_op_c = ALU_SUB;
      if (is_st)        imm_sel_c = 3'd1;
      else if (is_br)   imm_sel_c = 3'd2;
      else if (is_lui)  imm_sel_c = 3'd3;
      else if (is_jal)  imm_sel_c = 3'd4;
    end

    case (state_q)
      S_FETCH: ir_write_c = 1'b1;
      S_EXEC: begin
        if (is_br) begin
          pc_write_c = 1'b1;
          pc_src_c   = funct3[0] ? !bus.zero : bus.zero;
        end else if (is_jal) begin
          pc_write_c  = 1'b1;
          pc_src_c    = 1'b1;
          reg_write_c = 1'b1;
          wb_sel_c    = 2'd2;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_st;
        pc_write_c = is_st && bus.dmem_ready;
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        wb_sel_c    = is_ld ? 2'd1 : (is_lui ? 2'd3 : 2'd0);
      end
      S_HALT: halted_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_write  = pc_write_c;
  assign bus.pc_src    = pc_src_c;
  assign bus.ir_write  = ir_write_c;
  assign bus.reg_write = reg_write_c;
  assign bus.wb_sel    = wb_sel_c;
  assign bus.alu_src_a = alu_src_a_c;
  assign bus.alu_src_b = alu_src_b_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.imm_sel   = imm_sel_c;
  assign bus.dmem_req  = dmem_req_c;
  assign bus.dmem_we   = dmem_we_c;
  assign bus.halted    = halted_c;
  assign bus.fault     = fault_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors against hand-derived tables.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.ALUOP_W(4)) bus_if ();
  multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 32'd0;

  // Packed view: pcw pcs irw rw wb[1:0] sa sb op[3:0] imm[2:0] req we halted fault
  typedef logic [18:0] ctl_t;

  function automatic ctl_t cv(input logic pcw, pcs, irw, rw, input logic [1:0] wb,
                              input logic sa, sb, input logic [3:0] op, input logic [2:0] imm,
                              input logic req, we, h, f);
    return {pcw, pcs, irw, rw, wb, sa, sb, op, imm, req, we, h, f};
  endfunction

  function automatic ctl_t ctl_now();
    return {bus_if.pc_write, bus_if.pc_src, bus_if.ir_write, bus_if.reg_write, bus_if.wb_sel,
            bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.imm_sel,
            bus_if.dmem_req, bus_if.dmem_we, bus_if.halted, bus_if.fault};
  endfunction

  localparam ctl_t C_FETCH = 19'h10000;  // ir_write only
  localparam ctl_t C_IDLE  = 19'h00000;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.instruction = 32'h0000_0013;
    bus_if.zero = 1'b0;
    bus_if.dmem_ready = 1'b0;
    #1;
    checks++;
    if (ctl_now() !== C_FETCH) begin
      errors++; $display("FAIL reset_ctl: got %h want %h", ctl_now(), C_FETCH);
    end
    checks++;
    if (bus_if.retired !== 32'd0) begin
      errors++; $display("FAIL reset_retired: got %0d want 0", bus_if.retired);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    ctl_t seq [4];
    bus_if.instruction = 32'h0020_81B3;
    seq = '{C_FETCH, C_IDLE, C_IDLE, cv(1,0,0,1,2'd0,0,0,4'd0,3'd0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ctl_now() !== seq[i]) begin
        errors++; $display("FAIL add_cycle%0d: got %h want %h", i, ctl_now(), seq[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus_if.retired !== exp_ret) begin
          errors++; $display("FAIL add_retire_early: got %0d want %0d", bus_if.retired, exp_ret);
        end
      end
      step();
    end
    exp_ret++;
    checks++;
    if (bus_if.retired !== exp_ret || ctl_now() !== C_FETCH) begin
      errors++; $display("FAIL add_retired: got %0d/%h want %0d/%h", bus_if.retired, ctl_now(), exp_ret, C_FETCH);
    end
  endtask

  task automatic test_load();
    ctl_t seq [8];
    int   reqs = 0;
    ctl_t mem_c;
    mem_c = cv(0,0,0,0,2'd0,0,1,4'd0,3'd0,1,0,0,0);
    bus_if.instruction = 32'h0040_2283;
    seq = '{C_FETCH, C_IDLE, cv(0,0,0,0,2'd0,0,1,4'd0,3'd0,0,0,0,0), mem_c, mem_c, mem_c, mem_c,
            cv(1,0,0,1,2'd1,0,1,4'd0,3'd0,0,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      bus_if.dmem_ready = (i == 6);
      #1;
      checks++;
      if (ctl_now() !== seq[i]) begin
        errors++; $display("FAIL load_cycle%0d: got %h want %h", i, ctl_now(), seq[i]);
      end
      if (bus_if.dmem_req) reqs++;
      step();
    end
    bus_if.dmem_ready = 1'b0;
    exp_ret++;
    checks++;
    if (reqs != 4 || bus_if.retired !== exp_ret) begin
      errors++; $display("FAIL load_req_hold: got %0d reqs retired %0d want 4 reqs retired %0d", reqs, bus_if.retired, exp_ret);
    end
  endtask

  task automatic test_store();
    ctl_t seq [4];
    bus_if.instruction = 32'h0050_2423;
    seq = '{C_FETCH, C_IDLE, cv(0,0,0,0,2'd0,0,1,4'd0,3'd1,0,0,0,0),
            cv(1,0,0,0,2'd0,0,1,4'd0,3'd1,1,1,0,0)};
    for (int i = 0; i < 4; i++) begin
      bus_if.dmem_ready = (i == 3);
      #1;
      checks++;
      if (ctl_now() !== seq[i]) begin
        errors++; $display("FAIL store_cycle%0d: got %h want %h", i, ctl_now(), seq[i]);
      end
      step();
    end
    bus_if.dmem_ready = 1'b0;
    exp_ret++;
    checks++;
    if (bus_if.retired !== exp_ret || ctl_now() !== C_FETCH) begin
      errors++; $display("FAIL store_retired: got %0d/%h want %0d/%h", bus_if.retired, ctl_now(), exp_ret, C_FETCH);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [3];
    logic        zv  [3];
    logic        pcs [3];
    ctl_t        exp_ex;
    ins = '{32'h0020_8463, 32'h0020_8463, 32'h0020_9463};   // BEQ, BEQ, BNE
    zv  = '{1'b1, 1'b0, 1'b0};
    pcs = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      bus_if.instruction = ins[k];
      bus_if.zero = zv[k];
      exp_ex = cv(1,pcs[k],0,0,2'd0,0,0,4'd1,3'd2,0,0,0,0);
      step();
      step();
      checks++;
      if (ctl_now() !== exp_ex) begin
        errors++; $display("FAIL branch%0d_exec: got %h want %h", k, ctl_now(), exp_ex);
      end
      step();
      exp_ret++;
      checks++;
      if (bus_if.retired !== exp_ret || ctl_now() !== C_FETCH) begin
        errors++; $display("FAIL branch%0d_retire: got %0d/%h want %0d/%h", k, bus_if.retired, ctl_now(), exp_ret, C_FETCH);
      end
    end
    bus_if.zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    ctl_t lui_seq [4];
    bus_if.instruction = 32'h0100_00EF;   // JAL x1, 16
    step();
    step();
    checks++;
    if (ctl_now() !== cv(1,1,0,1,2'd2,1,1,4'd0,3'd4,0,0,0,0)) begin
      errors++; $display("FAIL jal_exec: got %h want %h", ctl_now(), cv(1,1,0,1,2'd2,1,1,4'd0,3'd4,0,0,0,0));
    end
    step();
    exp_ret++;
    bus_if.instruction = 32'h1234_53B7;   // LUI x7, 0x12345
    lui_seq = '{C_FETCH, C_IDLE, cv(0,0,0,0,2'd0,0,1,4'd0,3'd3,0,0,0,0),
                cv(1,0,0,1,2'd3,0,1,4'd0,3'd3,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ctl_now() !== lui_seq[i]) begin
        errors++; $display("FAIL lui_cycle%0d: got %h want %h", i, ctl_now(), lui_seq[i]);
      end
      step();
    end
    exp_ret++;
    checks++;
    if (bus_if.retired !== exp_ret) begin
      errors++; $display("FAIL b2b_retired: got %0d want %0d", bus_if.retired, exp_ret);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] ins [6];
    logic [3:0]  ops [6];
    logic        sbs [6];
    ctl_t        exp_wb;
    ins = '{32'h4020_81B3, 32'h4020_D1B3, 32'h0020_B1B3, 32'h0020_C1B3, 32'h4020_D193, 32'hC000_0093};
    ops = '{4'd1, 4'd7, 4'd9, 4'd4, 4'd7, 4'd0};           // SUB SRA SLTU XOR SRAI ADDI(bit30 set)
    sbs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      bus_if.instruction = ins[k];
      step();
      step();
      step();
      exp_wb = cv(1,0,0,1,2'd0,0,sbs[k],ops[k],3'd0,0,0,0,0);
      checks++;
      if (ctl_now() !== exp_wb) begin
        errors++; $display("FAIL alu%0d_wb: got %h want %h", k, ctl_now(), exp_wb);
      end
      step();
      exp_ret++;
    end
    checks++;
    if (bus_if.retired !== exp_ret) begin
      errors++; $display("FAIL alu_retired: got %0d want %0d", bus_if.retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_mem();
    bus_if.instruction = 32'h0040_2283;
    bus_if.dmem_ready = 1'b0;
    step();
    step();
    step();
    checks++;
    if (bus_if.dmem_req !== 1'b1) begin
      errors++; $display("FAIL midmem_req: got %b want 1", bus_if.dmem_req);
    end
    #2 reset = 1'b1;
    #1;
    exp_ret = 32'd0;
    checks++;
    if (ctl_now() !== C_FETCH || bus_if.retired !== 32'd0) begin
      errors++; $display("FAIL midmem_reset: got %h/%0d want %h/0", ctl_now(), bus_if.retired, C_FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    ctl_t mem_c;
    mem_c = cv(0,0,0,0,2'd0,0,1,4'd0,3'd1,1,1,0,0);
    bus_if.instruction = 32'h0050_2423;
    bus_if.dmem_ready = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ctl_now() !== mem_c) begin
        errors++; $display("FAIL timeout_mem%0d: got %h want %h", i, ctl_now(), mem_c);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctl_now() !== cv(0,0,0,0,2'd0,0,0,4'd0,3'd0,0,0,1,1) || bus_if.retired !== exp_ret) begin
        errors++; $display("FAIL timeout_halt%0d: got %h/%0d want %h/%0d", i, ctl_now(), bus_if.retired,
                           cv(0,0,0,0,2'd0,0,0,4'd0,3'd0,0,0,1,1), exp_ret);
      end
      step();
    end
    reset = 1'b1;
    #1;
    exp_ret = 32'd0;
    checks++;
    if (ctl_now() !== C_FETCH) begin
      errors++; $display("FAIL timeout_recover: got %h want %h", ctl_now(), C_FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_halts();
    logic [31:0] ins [3];
    logic        flt [3];
    ctl_t        exp_h;
    ins = '{32'h0000_007F, 32'h0000_0073, 32'h0020_A463};   // illegal, ECALL, branch funct3=010
    flt = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      bus_if.instruction = ins[k];
      step();
      step();
      exp_h = cv(0,0,0,0,2'd0,0,0,4'd0,3'd0,0,0,1,flt[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ctl_now() !== exp_h || bus_if.retired !== exp_ret) begin
          errors++; $display("FAIL halt%0d_cyc%0d: got %h/%0d want %h/%0d", k, i, ctl_now(), bus_if.retired, exp_h, exp_ret);
        end
        bus_if.instruction = 32'h0020_81B3;
        step();
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctl_now() !== C_FETCH) begin
        errors++; $display("FAIL halt%0d_recover: got %h want %h", k, ctl_now(), C_FETCH);
      end
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_alu_ops();
    test_reset_mid_mem();
    test_add();
    test_timeout();
    test_halts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
